// File: rtl/mda_text_pkg.sv
// Shared types and constants for the MDA text sequencer.
// Attribute field values, box-drawing range, fetch phases, cell bundle.
package mda_text_pkg;

    localparam logic [7:0] ATTR_BLANK0  = 8'h00;
    localparam logic [7:0] ATTR_BLANK1  = 8'h08;
    localparam logic [7:0] ATTR_REV     = 8'h70;
    localparam logic [2:0] ATTR_UL_MASK = 3'b001;

    localparam logic [7:0] CHAR_BOX_LO  = 8'hC0;
    localparam logic [7:0] CHAR_BOX_HI  = 8'hDF;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_P0,
        PH_P1
    } phase_t;

    // One decoded character cell waiting for the shifter.
    // bits[8] is the leftmost pixel, bits[0] the 9th column.
    typedef struct packed {
        logic [8:0] bits;
        logic       inten;
        logic       de;
        logic       hs;
        logic       vs;
    } cell_t;

endpackage

// File: rtl/mda_pixel_shifter.sv
// Pixel serializer: parallel load of a 9-bit cell, MSB-first serial out.
// Ports: clk, reset (sync, active-high), i_load, i_bits, i_inten, i_de,
//        i_hs, i_vs in; o_video, o_inten, o_de, o_hs, o_vs registered out.
module mda_pixel_shifter (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic [8:0] i_bits,
    input  logic       i_inten,
    input  logic       i_de,
    input  logic       i_hs,
    input  logic       i_vs,
    output logic       o_video,
    output logic       o_inten,
    output logic       o_de,
    output logic       o_hs,
    output logic       o_vs
);

    logic [8:0] r_shift;
    logic       r_inten_s;
    logic       r_de_s;
    logic       r_hs_s;
    logic       r_vs_s;

    // The cell-wide signals pass through the same two register stages
    // as the pixels, so syncs and enable stay aligned with pixel 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift   <= '0;
            r_inten_s <= 1'b0;
            r_de_s    <= 1'b0;
            r_hs_s    <= 1'b0;
            r_vs_s    <= 1'b0;
            o_video   <= 1'b0;
            o_inten   <= 1'b0;
            o_de      <= 1'b0;
            o_hs      <= 1'b0;
            o_vs      <= 1'b0;
        end else begin
            o_video <= r_shift[8];
            o_inten <= r_inten_s;
            o_de    <= r_de_s;
            o_hs    <= r_hs_s;
            o_vs    <= r_vs_s;
            if (i_load) begin
                r_shift   <= i_bits;
                r_inten_s <= i_inten;
                r_de_s    <= i_de;
                r_hs_s    <= i_hs;
                r_vs_s    <= i_vs;
            end else begin
                r_shift <= {r_shift[7:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mda_text_sequencer.sv
// MDA text-mode back end: fetch char/attr and glyph per cell, decode attrs, serialize.
// Ports: clk, reset, divclk, mem_addr, row_addr, display_enable, cursor, hsync, vsync,
//   vram_addr/vram_data, font_addr/font_data, video, intensity, hsync_o, vsync_o, de_o.
// Build option MDA_TEXT_SEQ_BLINK_EN adds the frame counter and attr[7] blink.
module mda_text_sequencer
    import mda_text_pkg::*;
#(
    parameter int GLYPH_W   = 9,
    parameter int UL_ROW    = 12,
    parameter int BLINK_BIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        divclk,
    input  logic [13:0] mem_addr,
    input  logic [4:0]  row_addr,
    input  logic        display_enable,
    input  logic        cursor,
    input  logic        hsync,
    input  logic        vsync,
    output logic [13:0] vram_addr,
    input  logic [15:0] vram_data,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    output logic        video,
    output logic        intensity,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        de_o
);

    localparam logic [8:0] COL_MASK = (GLYPH_W == 9) ? 9'h1FF : 9'h1FE;
    localparam logic [4:0] UL_ROW_V = 5'(UL_ROW);

    phase_t      r_phase;
    phase_t      w_phase_nxt;
    logic [13:0] r_vram_addr;
    logic [4:0]  r_row;
    logic        r_de;
    logic        r_cur;
    logic        r_hs;
    logic        r_vs;
    logic [7:0]  r_char;
    logic [7:0]  r_attr;
    cell_t       r_pend;
    cell_t       w_cell;

    logic        w_blank;
    logic        w_rev;
    logic        w_ul;
    logic        w_box;
    logic        w_blink_off;
    logic [8:0]  w_glyph;
    logic [8:0]  w_fg;
    logic [8:0]  w_bits;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= PH_IDLE;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_phase_nxt = PH_IDLE;
        case (r_phase)
            PH_IDLE: w_phase_nxt = PH_IDLE;
            PH_P0:   w_phase_nxt = PH_P1;
            PH_P1:   w_phase_nxt = PH_IDLE;
            default: w_phase_nxt = PH_IDLE;
        endcase
        if (divclk) begin
            w_phase_nxt = PH_P0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vram_addr <= '0;
            r_row       <= '0;
            r_de        <= 1'b0;
            r_cur       <= 1'b0;
            r_hs        <= 1'b0;
            r_vs        <= 1'b0;
            r_char      <= '0;
            r_attr      <= '0;
            r_pend      <= '0;
        end else begin
            if (divclk) begin
                r_vram_addr <= mem_addr;
                r_row       <= row_addr;
                r_de        <= display_enable;
                r_cur       <= cursor;
                r_hs        <= hsync;
                r_vs        <= vsync;
            end
            if (r_phase == PH_P0) begin
                r_char <= vram_data[7:0];
                r_attr <= vram_data[15:8];
            end
            if (r_phase == PH_P1) begin
                r_pend <= w_cell;
            end
        end
    end

    assign vram_addr = r_vram_addr;
    assign font_addr = {r_char, r_row[3:0]};

`ifdef MDA_TEXT_SEQ_BLINK_EN
    logic       r_vs_d;
    logic [4:0] r_frame;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vs_d  <= 1'b0;
            r_frame <= '0;
        end else begin
            r_vs_d <= vsync;
            if (vsync && !r_vs_d) begin
                r_frame <= r_frame + 5'd1;
            end
        end
    end

    assign w_blink_off = r_attr[7] & r_frame[BLINK_BIT];
`else
    logic w_unused_blink;

    assign w_unused_blink = r_attr[7] ^ (BLINK_BIT != 0);
    assign w_blink_off    = 1'b0;
`endif

    assign w_blank = (r_attr[6:0] == ATTR_BLANK0[6:0])
                  || (r_attr[6:0] == ATTR_BLANK1[6:0]);
    assign w_rev   = (r_attr[6:4] == ATTR_REV[6:4])
                  && (r_attr[2:0] == 3'b000);
    assign w_ul    = (r_attr[2:0] == ATTR_UL_MASK)
                  && (r_row == UL_ROW_V);
    assign w_box   = (r_char >= CHAR_BOX_LO)
                  && (r_char <= CHAR_BOX_HI);
    // Box-drawing chars extend their rightmost glyph pixel into column 9.
    assign w_glyph = {font_data, w_box & font_data[0]};

    // Priority: disabled area, then cursor, then blank, then reverse.
    always_comb begin
        w_fg = w_glyph;
        if (w_blink_off) begin
            w_fg = '0;
        end else if (w_ul) begin
            w_fg = '1;
        end
        w_bits = w_fg;
        if (!r_de) begin
            w_bits = '0;
        end else if (r_cur) begin
            w_bits = '1;
        end else if (w_blank) begin
            w_bits = '0;
        end else if (w_rev) begin
            w_bits = ~w_fg;
        end
        w_cell.bits  = w_bits & COL_MASK;
        w_cell.inten = r_de & r_attr[3] & (r_cur | ~w_blank);
        w_cell.de    = r_de;
        w_cell.hs    = r_hs;
        w_cell.vs    = r_vs;
    end

    mda_pixel_shifter u_shifter (
        .clk     (clk),
        .reset   (reset),
        .i_load  (divclk),
        .i_bits  (r_pend.bits),
        .i_inten (r_pend.inten),
        .i_de    (r_pend.de),
        .i_hs    (r_pend.hs),
        .i_vs    (r_pend.vs),
        .o_video (video),
        .o_inten (intensity),
        .o_de    (de_o),
        .o_hs    (hsync_o),
        .o_vs    (vsync_o)
    );

endmodule

// File: tb/tb_mda_text_sequencer.sv
// Bench for mda_text_sequencer: cell-level reference model plus per-cycle compare.
// Directed attribute cases, mid-cell reset, then randomized cells.
module tb_mda_text_sequencer;

    localparam int GW     = 9;
    localparam int UL_ROW = 12;
`ifdef MDA_TEXT_SEQ_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    typedef struct packed {
        logic [8:0] px;
        logic       hi;
        logic       de;
        logic       hs;
        logic       vs;
    } mcell_t;

    logic        clk;
    logic        reset;
    logic        divclk;
    logic [13:0] mem_addr;
    logic [4:0]  row_addr;
    logic        display_enable;
    logic        cursor;
    logic        hsync;
    logic        vsync;
    logic [13:0] vram_addr;
    logic [15:0] vram_data;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic        video;
    logic        intensity;
    logic        hsync_o;
    logic        vsync_o;
    logic        de_o;

    logic [15:0] vmem [0:63];
    logic [7:0]  fmem [0:4095];
    logic [7:0]  spec_at [0:10];

    int n_tests = 0;
    int n_fail  = 0;

    mcell_t m_old, m_disp, m_stage, e_c, pin;
    int     m_cnt   = 0;
    int     m_frame = 0;
    bit     m_vs_prev = 1'b0;
    bit     armed     = 1'b0;
    int     pi;
    logic   exp_v;

    mda_text_sequencer #(
        .GLYPH_W   (GW),
        .UL_ROW    (UL_ROW),
        .BLINK_BIT (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .divclk         (divclk),
        .mem_addr       (mem_addr),
        .row_addr       (row_addr),
        .display_enable (display_enable),
        .cursor         (cursor),
        .hsync          (hsync),
        .vsync          (vsync),
        .vram_addr      (vram_addr),
        .vram_data      (vram_data),
        .font_addr      (font_addr),
        .font_data      (font_data),
        .video          (video),
        .intensity      (intensity),
        .hsync_o        (hsync_o),
        .vsync_o        (vsync_o),
        .de_o           (de_o)
    );

    // Memories answer from the registered addresses the DUT drives.
    assign vram_data = vmem[vram_addr[5:0]];
    assign font_data = fmem[font_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // What one cell must look like, pixel by pixel; px bit p is pixel p.
    function automatic mcell_t model_cell(
        input logic [7:0] ch, input logic [7:0] at, input logic [7:0] gl,
        input logic [4:0] row, input logic de, input logic cur,
        input logic hs, input logic vs, input int frame);
        mcell_t c;
        bit blank, rev, ul, box, boff, fg, pix;
        int a7;
        c = '0;
        c.de = de;
        c.hs = hs;
        c.vs = vs;
        a7    = int'(at) % 128;
        blank = (a7 == 0) || (a7 == 8);
        rev   = (a7 / 16 == 7) && (a7 % 8 == 0);
        ul    = (a7 % 8 == 1) && (int'(row) == UL_ROW);
        box   = (int'(ch) >= 192) && (int'(ch) <= 223);
        boff  = BLINK && (int'(at) >= 128) && ((frame / 16) % 2 == 1);
        for (int p = 0; p < GW; p++) begin
            if (p < 8) fg = ((int'(gl) >> (7 - p)) % 2) == 1;
            else       fg = box && (int'(gl) % 2 == 1);
            if (boff)    fg = 1'b0;
            else if (ul) fg = 1'b1;
            if (!de)        pix = 1'b0;
            else if (cur)   pix = 1'b1;
            else if (blank) pix = 1'b0;
            else if (rev)   pix = !fg;
            else            pix = fg;
            c.px[p] = pix;
        end
        c.hi = de && ((int'(at) / 8) % 2 == 1) && (cur || !blank);
        return c;
    endfunction

    // Reference timeline: a cell fetched at one divclk shows after the next.
    always @(posedge clk) begin
        if (reset) begin
            m_old     = '0;
            m_disp    = '0;
            m_stage   = '0;
            m_cnt     = 1;
            m_frame   = 0;
            m_vs_prev = 1'b0;
            armed     = 1'b1;
        end else if (armed) begin
            if (vsync && !m_vs_prev) m_frame = (m_frame + 1) % 32;
            m_vs_prev = vsync;
            if (divclk) begin
                m_old   = m_disp;
                m_disp  = m_stage;
                m_stage = model_cell(vmem[mem_addr[5:0]][7:0],
                                     vmem[mem_addr[5:0]][15:8],
                                     fmem[{vmem[mem_addr[5:0]][7:0],
                                           row_addr[3:0]}],
                                     row_addr, display_enable, cursor,
                                     hsync, vsync, m_frame);
                m_cnt = 0;
            end else if (m_cnt < 100) begin
                m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            if (m_cnt == 0) begin
                e_c = m_old;
                pi  = GW - 1;
            end else begin
                e_c = m_disp;
                pi  = m_cnt - 1;
            end
            exp_v = (pi < GW) ? e_c.px[pi] : 1'b0;
            chk("video",     32'(video),     32'(exp_v));
            chk("intensity", 32'(intensity), 32'(e_c.hi));
            chk("hsync_o",   32'(hsync_o),   32'(e_c.hs));
            chk("vsync_o",   32'(vsync_o),   32'(e_c.vs));
            chk("de_o",      32'(de_o),      32'(e_c.de));
        end
    end

    task automatic run_cell(input logic [13:0] a, input logic [4:0] row,
                            input logic de, input logic cur,
                            input logic hs, input logic vs,
                            input int rst_at, input bit chk_blank);
        mem_addr       = a;
        row_addr       = row;
        display_enable = de;
        cursor         = cur;
        hsync          = hs;
        vsync          = vs;
        divclk         = 1'b1;
        @(posedge clk);
        #1 divclk = 1'b0;
        for (int i = 1; i < GW; i++) begin
            reset = (i == rst_at);
            @(posedge clk);
            if (i == rst_at) begin
                @(negedge clk);
                chk("reset_blank_video", 32'(video), 32'd0);
            end else if (chk_blank && i == 4) begin
                @(negedge clk);
                chk("post_reset_cell", {29'd0, video, hsync_o, de_o}, 32'd0);
            end else begin
                #1;
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        spec_at[0] = 8'h00; spec_at[1] = 8'h08; spec_at[2]  = 8'h70;
        spec_at[3] = 8'hF0; spec_at[4] = 8'h01; spec_at[5]  = 8'h09;
        spec_at[6] = 8'h81; spec_at[7] = 8'h07; spec_at[8]  = 8'h0F;
        spec_at[9] = 8'h87; spec_at[10] = 8'h78;
        for (int i = 0; i < 4096; i++) fmem[i] = 8'($urandom);
        for (int i = 8; i < 64; i++) begin
            vmem[i][15:8] = ($urandom_range(0, 1) == 0)
                          ? spec_at[$urandom_range(0, 10)] : 8'($urandom);
            vmem[i][7:0]  = ($urandom_range(0, 2) == 0)
                          ? 8'($urandom_range(192, 223)) : 8'($urandom);
        end
        vmem[0] = 16'h0741; vmem[1] = 16'h0FC4; vmem[2] = 16'h0F41;
        vmem[3] = 16'h7050; vmem[4] = 16'h00C4; vmem[5] = 16'h0141;
        vmem[6] = 16'h8741; vmem[7] = 16'h70C4;
        fmem[{8'h41, 4'd2}]  = 8'h3C;
        fmem[{8'hC4, 4'd3}]  = 8'hFF;
        fmem[{8'h41, 4'd3}]  = 8'hFF;
        fmem[{8'h50, 4'd4}]  = 8'hF0;
        fmem[{8'h41, 4'd12}] = 8'h18;
        fmem[{8'h41, 4'd11}] = 8'h18;

        // Pin the model against hand-derived cells.
        pin = model_cell(8'h41, 8'h07, 8'h3C, 5'd2, 1, 0, 0, 0, 0);
        chk("pin_basic_px", 32'(pin.px), 32'h03C);
        chk("pin_basic_int", 32'(pin.hi), 32'd0);
        pin = model_cell(8'hC4, 8'h0F, 8'hFF, 5'd3, 1, 0, 0, 0, 0);
        chk("pin_box_px", 32'(pin.px), 32'h1FF);
        chk("pin_box_int", 32'(pin.hi), 32'd1);
        pin = model_cell(8'h41, 8'h0F, 8'hFF, 5'd3, 1, 0, 0, 0, 0);
        chk("pin_nobox_px", 32'(pin.px), 32'h0FF);
        pin = model_cell(8'h50, 8'h70, 8'hF0, 5'd4, 1, 0, 0, 0, 0);
        chk("pin_rev_px", 32'(pin.px), 32'h1F0);
        pin = model_cell(8'hC4, 8'h00, 8'hFF, 5'd3, 1, 0, 0, 0, 0);
        chk("pin_blank_px", 32'(pin.px), 32'h000);
        pin = model_cell(8'h41, 8'h01, 8'h18, 5'd12, 1, 0, 0, 0, 0);
        chk("pin_ul_px", 32'(pin.px), 32'h1FF);
        pin = model_cell(8'h41, 8'h01, 8'h18, 5'd11, 1, 0, 0, 0, 0);
        chk("pin_noul_px", 32'(pin.px), 32'h018);
        pin = model_cell(8'h50, 8'h70, 8'hF0, 5'd4, 1, 1, 0, 0, 0);
        chk("pin_cursor_px", 32'(pin.px), 32'h1FF);
        pin = model_cell(8'h50, 8'h0F, 8'hF0, 5'd4, 0, 1, 1, 0, 0);
        chk("pin_de0", {22'd0, pin.px, pin.hi}, 32'd0);
`ifdef MDA_TEXT_SEQ_BLINK_EN
        pin = model_cell(8'h41, 8'h87, 8'h3C, 5'd2, 1, 0, 0, 0, 3);
        chk("pin_blink_on", 32'(pin.px), 32'h03C);
        pin = model_cell(8'h41, 8'h87, 8'h3C, 5'd2, 1, 0, 0, 0, 20);
        chk("pin_blink_off", 32'(pin.px), 32'h000);
`endif

        reset = 1'b1; divclk = 1'b0; mem_addr = '0; row_addr = '0;
        display_enable = 1'b0; cursor = 1'b0; hsync = 1'b0; vsync = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {27'd0, video, intensity, hsync_o, vsync_o, de_o},
            32'd0);
        chk("rst_vram_addr", 32'(vram_addr), 32'd0);
        chk("rst_font_addr", 32'(font_addr), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        run_cell(14'd0, 5'd2, 1, 0, 1, 0, -1, 0);
        run_cell(14'd1, 5'd3, 1, 0, 0, 0, -1, 0);
        run_cell(14'd2, 5'd3, 1, 0, 1, 0, -1, 0);
        run_cell(14'd3, 5'd4, 1, 0, 0, 1, -1, 0);
        run_cell(14'd4, 5'd3, 1, 0, 1, 0, -1, 0);
        run_cell(14'd5, 5'd12, 1, 0, 0, 0, -1, 0);
        run_cell(14'd5, 5'd11, 1, 0, 1, 0, -1, 0);
        run_cell(14'd7, 5'd3, 1, 1, 0, 0, -1, 0);
        run_cell(14'd0, 5'd2, 0, 1, 1, 0, -1, 0);

        run_cell(14'd1, 5'd3, 1, 0, 1, 0, -1, 0);
        run_cell(14'd1, 5'd3, 1, 0, 1, 0, 4, 0);
        run_cell(14'd2, 5'd3, 1, 0, 1, 0, -1, 1);
        run_cell(14'd0, 5'd2, 1, 0, 1, 0, -1, 0);
        run_cell(14'd1, 5'd3, 1, 0, 1, 0, -1, 0);

`ifdef MDA_TEXT_SEQ_BLINK_EN
        for (int f = 0; f < 36; f++) begin
            run_cell(14'd6, 5'd2, 1, 0, 0, 1, -1, 0);
            run_cell(14'd6, 5'd2, 1, (f % 3 == 0), 0, 0, -1, 0);
        end
`endif

        for (int k = 0; k < 400; k++) begin
            run_cell({8'($urandom), 6'($urandom_range(0, 63))},
                     5'($urandom_range(0, 31)),
                     $urandom_range(0, 7) != 0,
                     $urandom_range(0, 7) == 0,
                     1'($urandom),
                     $urandom_range(0, 3) == 0,
                     -1, 0);
        end
        run_cell(14'd0, 5'd2, 1, 0, 0, 0, -1, 0);
        run_cell(14'd0, 5'd2, 1, 0, 0, 0, -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
